// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must reach WIDTH without wrapping, hence the extra bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return int'($clog2(w)) + 1;
  endfunction

endpackage

// File: rtl/sub4_serial_if.sv
// Start/done handshake plus operand and result bus for sub4_serial.
interface sub4_serial_if
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, ina, inb, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, ina, inb, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/full_sub1.sv
// Combinational 1-bit full subtractor: a - b - br -> d with borrow br_next.
module full_sub1 (
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic br_next
);

  // Difference bit and borrow-out of a single cell
  assign d       = a ^ b ^ br;
  assign br_next = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/sub4_serial.sv
// Bit-serial subtractor: {bout, diff} = ina - inb - bin, LSB first, one bit per clock.
module sub4_serial
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  sub4_serial_if.slave  bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;

  logic             d_c;
  logic             br_c;
  logic             last_c;
  logic             accept_c;

  // The single reused subtractor cell works on the current LSBs
  full_sub1 u_fs (
    .a       (a_q[0]),
    .b       (b_q[0]),
    .br      (br_q),
    .d       (d_c),
    .br_next (br_c)
  );

  assign last_c   = (cnt_q == CW'(WIDTH - 1));
  assign accept_c = (state_q == IDLE) && bus.start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_c)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs follow the upcoming state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.busy <= (state_d == RUN);
      bus.done <= (state_d == DONE);
    end
  end

  // Operand shifters, borrow flop, counter and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
    end else if (accept_c) begin
      a_q   <= bus.ina;
      b_q   <= bus.inb;
      br_q  <= bus.bin;
      cnt_q <= '0;
      res_q <= '0;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      br_q  <= br_c;
      cnt_q <= cnt_q + CW'(1);
      res_q <= {d_c, res_q[WIDTH-1:1]};
      // Last bit: publish the full result as the FSM enters DONE
      if (last_c) begin
        bus.diff <= {d_c, res_q[WIDTH-1:1]};
        bus.bout <= br_c;
      end
    end
  end

endmodule

// File: tb/tb_sub4_serial.sv
// Self-checking bench for sub4_serial: vector table, corner sequences, exhaustive adder cross-check.
module tb_sub4_serial;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;

  sub4_serial_if #(.WIDTH(W)) bus ();

  sub4_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic [3:0] ed;
    logic       eb;
  } vec_t;

  vec_t       vecs [6];
  logic [4:0] exp_q [$];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // One operation: pulse start, push expectation, wait for done, compare
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                        input bit scramble);
    logic [4:0] e;
    logic [4:0] got;
    logic [4:0] s;
    int         lat;
    bit         seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.ina   = a;
    bus.inb   = b;
    bus.bin   = bi;
    e = 5'(a) - 5'(b) - 5'(bi);
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 20) begin
      if (scramble && lat == 2) begin
        bus.ina = ~a;
        bus.inb = ~b;
        bus.bin = ~bi;
      end
      if (bus.done) begin
        seen = 1'b1;
        check("latency", 32'(lat), 32'(W + 1));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        got = {bus.bout, bus.diff};
        if (exp_q.size() > 0) check("scoreboard", 32'(got), 32'(exp_q.pop_front()));
        s = 5'(bus.diff) + 5'(b) + 5'(bi);
        check("adder_sum", 32'(s[3:0]), 32'(a));
        check("adder_cout", 32'(s[4]), 32'(bus.bout));
      end else begin
        if (lat <= W) check("busy_run", 32'(bus.busy), 32'd1);
        lat++;
        @(negedge clk);
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    int done_cnt;
    int last_done;
    vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
    vecs[1] = '{4'd3,  4'd9,  1'b0, 4'hA,  1'b1};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1};
    vecs[3] = '{4'd15, 4'd15, 1'b1, 4'hF,  1'b1};
    vecs[4] = '{4'd15, 4'd0,  1'b0, 4'd15, 1'b0};
    vecs[5] = '{4'd12, 4'd5,  1'b0, 4'd7,  1'b0};

    bus.start = 1'b0;
    bus.ina   = '0;
    bus.inb   = '0;
    bus.bin   = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
    rst = 1'b0;

    // Table vectors with explicit expected outputs
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bi, 1'b0);
      check("vec_diff", 32'(bus.diff), 32'(vecs[i].ed));
      check("vec_bout", 32'(bus.bout), 32'(vecs[i].eb));
    end

    // Result holds after done
    run_op(4'd9, 4'd3, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("hold_diff", 32'(bus.diff), 32'd6);
    check("hold_bout", 32'(bus.bout), 32'd0);
    check("hold_done", 32'(bus.done), 32'd0);

    // Operands changed mid-RUN must not leak in
    run_op(4'd12, 4'd5, 1'b0, 1'b1);
    check("scramble_diff", 32'(bus.diff), 32'd7);

    // Start held high: one result every WIDTH+2 cycles
    @(negedge clk);
    bus.ina   = 4'd9;
    bus.inb   = 4'd3;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    done_cnt  = 0;
    last_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.busy && bus.done) check("busy_and_done", 32'd1, 32'(bus.busy & ~bus.done));
      if (bus.done) begin
        done_cnt++;
        check("held_diff", 32'(bus.diff), 32'd6);
        if (last_done != 0) check("held_gap", 32'(c - last_done), 32'(W + 2));
        last_done = c;
      end
    end
    check("held_count", 32'(done_cnt), 32'd3);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    // Reset in the middle of a run discards it
    @(negedge clk);
    bus.ina   = 4'd12;
    bus.inb   = 4'd5;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_diff", 32'(bus.diff), 32'd0);
    check("mid_rst_bout", 32'(bus.bout), 32'd0);
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    run_op(4'd12, 4'd5, 1'b0, 1'b0);
    check("after_rst_diff", 32'(bus.diff), 32'd7);
    check("after_rst_bout", 32'(bus.bout), 32'd0);

    // Exhaustive cross-check against the ripple-adder relation
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bi = 0; bi < 2; bi++)
          run_op(4'(a), 4'(b), 1'(bi), 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub4_serial.md
# sub4_serial

Bit-serial subtractor computing {bout, diff} = ina − inb − bin, LSB first, one bit per clock, with a start/done handshake. It is the inverse datapath companion to the team's 4-bit ripple adder. Its results are checked against that adder: diff + inb + bin must equal ina with the adder's carry-out equal to bout. It sits behind a stimulus block that loads operands and waits for done. It trades area for latency: one full-subtractor cell is reused across WIDTH cycles.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- ina  input  WIDTH  minuend, captured on accepted start
- inb  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse, result valid
- diff  output  WIDTH  difference, held until next accepted start
- bout  output  1  borrow-out, held with diff

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1: latch ina/inb into shift registers, load borrow register ← bin, clear bit counter, go to RUN. IDLE with start=0: stay.
- RUN, each cycle: process bit i = counter, LSB first.
  - d = a0 ^ b0 ^ br
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift d into the result register from the MSB side.
  - Shift the operand registers right.
  - Increment the counter.
- After the WIDTH-th RUN cycle: go to DONE.
- DONE: done=1, diff = assembled result, bout = final borrow. Next cycle go to IDLE unconditionally.
- Arithmetic: {bout, diff} = (ina − inb − bin) mod 2^(WIDTH+1). bout=1 iff ina < inb + bin (unsigned).
- start while in RUN or DONE is ignored; no queuing. Operand inputs are ignored outside an accepted start.
- diff/bout update only on entry to DONE. Between results they hold the previous values.
- Reset (any state, including mid-RUN): state→IDLE, the in-flight operation is discarded, and all outputs clear.

## Timing
- Reset values: busy=0, done=0, diff=0, bout=0, counter=0, state IDLE.
- Let start be sampled high at edge E0.
  - busy is high from after E0 through edge E_WIDTH (WIDTH cycles).
  - done is high for exactly the cycle after edge E_WIDTH, i.e. the (WIDTH+1)-th cycle after start.
- Earliest next accepted start: the cycle after done, one cycle in IDLE. Throughput is one result per WIDTH+2 cycles.
- busy and done are never high together.
- Counter width is clog2(WIDTH)+1. The wrap at WIDTH−1→exit is an exact compare, with no modulo reuse.

## Structure
- Shared package sub_pkg:
  - state enum {IDLE, RUN, DONE}
  - default WIDTH constant
  - counter-width function
- One sub-module, full_sub1: combinational 1-bit full subtractor (a, b, br → d, br'). It is instantiated once in sub4_serial.
- The top level holds the FSM, operand/result shift registers, borrow flop and counter. The expected size is 150–250 lines total.

## Test plan
- Basic subtraction: ina=9, inb=3, bin=0, start for 1 cycle.
  - busy high 4 cycles, then done pulse with diff=6, bout=0.
  - diff/bout still 6/0 five cycles later.
- Borrow cases:
  - ina=3, inb=9, bin=0 → diff=4'hA, bout=1.
  - ina=0, inb=0, bin=1 → diff=4'hF, bout=1.
  - ina=15, inb=15, bin=1 → diff=4'hF, bout=1.
  - ina=15, inb=0, bin=0 → diff=15, bout=0.
- Ignored start:
  - Start held high continuously: accepted only in IDLE. done pulses every 6 cycles.
  - Operands changed mid-RUN do not affect the in-flight result.
- Reset mid-operation:
  - Assert rst at the 2nd RUN cycle of 12−5: next cycle busy=0, done=0, diff=0, bout=0, and no done pulse follows.
  - A new start of 12−5 then yields diff=7, bout=0.
- Exhaustive cross-check against the ripple adder, all 512 (ina, inb, bin) combinations:
  - Adder(diff, inb, bin) must give sum=ina.
  - The adder's cout must equal bout.
  - Latency is exactly WIDTH+1 cycles per operation.
